// File: rtl/cachebusarb_if.sv
// cachebusarb_if: signal bundle between the line sequencer (master), the two caches and the external bus.
interface cachebusarb_if #(
   parameter int PA_BITS  = 34,
   parameter int LINELEN  = 512,
   parameter int BUSWIDTH = 64,
   parameter int LOGBWPL  = $clog2(LINELEN/BUSWIDTH)
);
   logic [1:0]          IFUCacheBusRW;
   logic [PA_BITS-1:0]  IFUCacheBusAdr;
   logic                IFUCacheBusAck;
   logic [1:0]          LSUCacheBusRW;
   logic [PA_BITS-1:0]  LSUCacheBusAdr;
   logic [BUSWIDTH-1:0] LSUWriteBeat;
   logic                LSUCacheBusAck;
   logic [LOGBWPL-1:0]  BeatCount;
   logic                SelBusBeat;
   logic [LINELEN-1:0]  FetchBuffer;
   logic                BusReq;
   logic                BusWrite;
   logic [PA_BITS-1:0]  BusAdr;
   logic [BUSWIDTH-1:0] BusWData;
   logic                BusReady;
   logic [BUSWIDTH-1:0] BusRData;

   modport master (
      input  IFUCacheBusRW, IFUCacheBusAdr, LSUCacheBusRW, LSUCacheBusAdr, LSUWriteBeat,
             BusReady, BusRData,
      output IFUCacheBusAck, LSUCacheBusAck, BeatCount, SelBusBeat, FetchBuffer,
             BusReq, BusWrite, BusAdr, BusWData
   );

   modport slave (
      output IFUCacheBusRW, IFUCacheBusAdr, LSUCacheBusRW, LSUCacheBusAdr, LSUWriteBeat,
             BusReady, BusRData,
      input  IFUCacheBusAck, LSUCacheBusAck, BeatCount, SelBusBeat, FetchBuffer,
             BusReq, BusWrite, BusAdr, BusWData
   );
endinterface

// File: rtl/cachebusarb.sv
// cachebusarb: arbitrates and sequences whole-line I$/D$ fills and D$ writebacks over one beat-wide bus.
// Build macro CACHEBUSARB_RR_EN selects round-robin arbitration; default is fixed priority D$ over I$.
module cachebusarb #(
   parameter int PA_BITS  = 34,
   parameter int LINELEN  = 512,
   parameter int BUSWIDTH = 64,
   parameter int LOGBWPL  = $clog2(LINELEN/BUSWIDTH)
) (
   input logic           clk,
   input logic           reset,
   cachebusarb_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

   localparam logic [LOGBWPL-1:0] LAST_BEAT  = LOGBWPL'(LINELEN/BUSWIDTH - 1);
   localparam logic [LOGBWPL-1:0] ONE_BEAT   = LOGBWPL'(1);
   localparam logic [PA_BITS-1:0] BEAT_BYTES = PA_BITS'(BUSWIDTH/8);

   state_t              state;
   logic                owner_lsu;
   logic                lock;
   logic                bus_req;
   logic                bus_write;
   logic                sel_bus_beat;
   logic                ifu_ack;
   logic                lsu_ack;
   logic [PA_BITS-1:0]  bus_adr;
   logic [LOGBWPL-1:0]  beat_count;
   logic [LINELEN-1:0]  fetch_buffer;
   logic                lsu_req;
   logic                ifu_req;
   logic                locked_grant;
   logic                grant_lsu;
`ifdef CACHEBUSARB_RR_EN
   logic                rr_ptr;   // 1: D$ was served last, so the I$ wins the next contention
`endif

   // Pick the owner of the next burst from the two cache requests
   always_comb begin
      lsu_req      = |bus.LSUCacheBusRW;
      ifu_req      = |bus.IFUCacheBusRW;
      locked_grant = lock & lsu_req;
      grant_lsu    = 1'b0;
      if (locked_grant) begin
         grant_lsu = 1'b1;
`ifdef CACHEBUSARB_RR_EN
      end else if (lsu_req && ifu_req) begin
         grant_lsu = ~rr_ptr;
`endif
      end else begin
         grant_lsu = lsu_req;
      end
   end

   // Burst sequencer: state, beat counter, fetch buffer and every registered output
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         owner_lsu    <= 1'b0;
         lock         <= 1'b0;
         bus_req      <= 1'b0;
         bus_write    <= 1'b0;
         sel_bus_beat <= 1'b0;
         ifu_ack      <= 1'b0;
         lsu_ack      <= 1'b0;
         bus_adr      <= '0;
         beat_count   <= '0;
         fetch_buffer <= '0;
`ifdef CACHEBUSARB_RR_EN
         rr_ptr       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               lock <= 1'b0;
               if (lsu_req || ifu_req) begin
                  state        <= BURST;
                  owner_lsu    <= grant_lsu;
                  bus_req      <= 1'b1;
                  bus_write    <= grant_lsu & bus.LSUCacheBusRW[0];
                  bus_adr      <= grant_lsu ? bus.LSUCacheBusAdr : bus.IFUCacheBusAdr;
                  sel_bus_beat <= grant_lsu;
                  beat_count   <= '0;
`ifdef CACHEBUSARB_RR_EN
                  if (!locked_grant) begin
                     rr_ptr <= grant_lsu;
                  end
`endif
               end
            end
            BURST: begin
               if (bus.BusReady) begin
                  if (!bus_write) begin
                     fetch_buffer[beat_count*BUSWIDTH +: BUSWIDTH] <= bus.BusRData;
                  end
                  if (beat_count == LAST_BEAT) begin
                     state      <= DONE;
                     bus_req    <= 1'b0;
                     bus_write  <= 1'b0;
                     beat_count <= '0;
                     ifu_ack    <= ~owner_lsu;
                     lsu_ack    <= owner_lsu;
                     // a finished writeback keeps the bus for the D$ refill that follows it
                     lock       <= owner_lsu & bus_write;
                  end else begin
                     beat_count <= beat_count + ONE_BEAT;
                     bus_adr    <= bus_adr + BEAT_BYTES;
                  end
               end
            end
            DONE: begin
               state        <= IDLE;
               ifu_ack      <= 1'b0;
               lsu_ack      <= 1'b0;
               sel_bus_beat <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.IFUCacheBusAck = ifu_ack;
   assign bus.LSUCacheBusAck = lsu_ack;
   assign bus.BeatCount      = beat_count;
   assign bus.SelBusBeat     = sel_bus_beat;
   assign bus.FetchBuffer    = fetch_buffer;
   assign bus.BusReq         = bus_req;
   assign bus.BusWrite       = bus_write;
   assign bus.BusAdr         = bus_adr;
   assign bus.BusWData       = bus.LSUWriteBeat;
endmodule

// File: tb/tb_cachebusarb.sv
// tb_cachebusarb: directed table-driven bench for cachebusarb plus hand-written multi-cycle sequences.
module tb_cachebusarb;
   localparam int PA_BITS  = 34;
   localparam int LINELEN  = 512;
   localparam int BUSWIDTH = 64;
   localparam int LOGBWPL  = 3;

   typedef struct {
      logic [1:0]         ifu_rw;
      logic [PA_BITS-1:0] ifu_adr;
      logic [1:0]         lsu_rw;
      logic [PA_BITS-1:0] lsu_adr;
      logic               stall;
      int                 drop_cyc;
      logic               exp_lsu;
      logic               exp_write;
   } vec_t;

   logic               clk = 1'b0;
   logic               reset;
   int                 checks = 0;
   int                 errors = 0;
   logic [LINELEN-1:0] exp_fb;
   vec_t               vecs [6];

   cachebusarb_if #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSWIDTH(BUSWIDTH), .LOGBWPL(LOGBWPL)) bus ();

   cachebusarb #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSWIDTH(BUSWIDTH), .LOGBWPL(LOGBWPL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] wdata(input logic [2:0] i);
      return {32'hBEEF_0000, 29'd0, i};
   endfunction

   function automatic logic [63:0] rdata(input logic [PA_BITS-1:0] a);
      return {a[33:2], ~a[31:0]};
   endfunction

   // D$ presents the writeback word picked by BeatCount; memory answers with an address-derived word
   assign bus.LSUWriteBeat = wdata(bus.BeatCount);
   assign bus.BusRData     = rdata(bus.BusAdr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [LINELEN-1:0] act, input logic [LINELEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " busreq"}, 64'(bus.BusReq), 64'd0);
      chk({tag, " buswrite"}, 64'(bus.BusWrite), 64'd0);
      chk({tag, " acks"}, 64'({bus.LSUCacheBusAck, bus.IFUCacheBusAck}), 64'd0);
      chk({tag, " selbusbeat"}, 64'(bus.SelBusBeat), 64'd0);
      chk({tag, " beatcount"}, 64'(bus.BeatCount), 64'd0);
      chk({tag, " busadr"}, 64'(bus.BusAdr), 64'd0);
      chkw({tag, " fetchbuf"}, bus.FetchBuffer, '0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      bus.IFUCacheBusRW  = 2'b00;
      bus.IFUCacheBusAdr = '0;
      bus.LSUCacheBusRW  = 2'b00;
      bus.LSUCacheBusAdr = '0;
      bus.BusReady       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals(tag);
      exp_fb = '0;
      reset  = 1'b0;
   endtask

   // Starts at a negedge with the DUT about to sample in IDLE; ends at the negedge of the next IDLE cycle
   task automatic do_txn(input string tag, input vec_t v);
      logic [PA_BITS-1:0] base;
      int   beat;
      int   cyc;
      logic rdy;
      logic done;
      base = v.exp_lsu ? v.lsu_adr : v.ifu_adr;
      bus.IFUCacheBusRW  = v.ifu_rw;
      bus.IFUCacheBusAdr = v.ifu_adr;
      bus.LSUCacheBusRW  = v.lsu_rw;
      bus.LSUCacheBusAdr = v.lsu_adr;
      @(posedge clk);
      @(negedge clk);
      beat = 0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         chk({tag, " busreq"}, 64'(bus.BusReq), 64'd1);
         chk({tag, " buswrite"}, 64'(bus.BusWrite), 64'(v.exp_write));
         chk({tag, " beatcount"}, 64'(bus.BeatCount), 64'(beat));
         chk({tag, " busadr"}, 64'(bus.BusAdr), 64'(base + PA_BITS'(beat*8)));
         chk({tag, " selbusbeat"}, 64'(bus.SelBusBeat), 64'(v.exp_lsu));
         chk({tag, " ack early"}, 64'({bus.LSUCacheBusAck, bus.IFUCacheBusAck}), 64'd0);
         if (v.exp_write) begin
            chk({tag, " wdata"}, bus.BusWData, wdata(3'(beat)));
         end
         rdy = v.stall ? (cyc % 2 == 1) : 1'b1;
         bus.BusReady = rdy;
         if (cyc == v.drop_cyc) begin
            bus.IFUCacheBusRW = 2'b00;
         end
         @(posedge clk);
         if (rdy) begin
            if (!v.exp_write) begin
               exp_fb[beat*64 +: 64] = rdata(base + PA_BITS'(beat*8));
            end
            done = (beat == 7);
            beat++;
         end
         cyc++;
         @(negedge clk);
      end
      bus.BusReady = 1'b0;
      chk({tag, " done busreq"}, 64'(bus.BusReq), 64'd0);
      chk({tag, " done buswrite"}, 64'(bus.BusWrite), 64'd0);
      chk({tag, " ack"}, 64'({bus.LSUCacheBusAck, bus.IFUCacheBusAck}), v.exp_lsu ? 64'd2 : 64'd1);
      chk({tag, " done beatcount"}, 64'(bus.BeatCount), 64'd0);
      chk({tag, " done selbusbeat"}, 64'(bus.SelBusBeat), 64'(v.exp_lsu));
      chkw({tag, " fetchbuf"}, bus.FetchBuffer, exp_fb);
      if (v.exp_lsu) begin
         bus.LSUCacheBusRW = 2'b00;
      end else begin
         bus.IFUCacheBusRW = 2'b00;
      end
      @(negedge clk);
      chk({tag, " idle acks"}, 64'({bus.LSUCacheBusAck, bus.IFUCacheBusAck}), 64'd0);
      chk({tag, " idle busreq"}, 64'(bus.BusReq), 64'd0);
      chk({tag, " idle selbusbeat"}, 64'(bus.SelBusBeat), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      vecs[0] = '{2'b10, 34'h0_8000_0040, 2'b00, 34'h0,           1'b0, -1, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 34'h0,           2'b10, 34'h1_0000_0200, 1'b0, -1, 1'b1, 1'b0};
      vecs[2] = '{2'b00, 34'h0,           2'b01, 34'h0_0000_0100, 1'b0, -1, 1'b1, 1'b1};
      vecs[3] = '{2'b10, 34'h0_1234_5600, 2'b00, 34'h0,           1'b1, -1, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 34'h0_0000_0FC0, 2'b00, 34'h0,           1'b0,  3, 1'b0, 1'b0};
      vecs[5] = '{2'b00, 34'h0,           2'b10, 34'h3_FFFF_FFC0, 1'b0, -1, 1'b1, 1'b0};

      reset = 1'b1;
      apply_reset("reset");

      for (int i = 0; i < 6; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i]);
      end

      // reset at beat 3 of a fill: no Ack, everything back to reset values, then a clean restart
      bus.IFUCacheBusRW  = 2'b10;
      bus.IFUCacheBusAdr = 34'h0_0000_0500;
      bus.BusReady       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("midrst beat3", 64'(bus.BeatCount), 64'd3);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midrst");
      reset              = 1'b0;
      bus.BusReady       = 1'b0;
      bus.IFUCacheBusRW  = 2'b00;
      exp_fb             = '0;
      @(negedge clk);
      chk("midrst no ack", 64'({bus.LSUCacheBusAck, bus.IFUCacheBusAck}), 64'd0);
      chk("midrst idle busreq", 64'(bus.BusReq), 64'd0);
      v = '{2'b10, 34'h0_0000_0600, 2'b00, 34'h0, 1'b0, -1, 1'b0, 1'b0};
      do_txn("restart", v);

      // writeback then locked refill while the I$ keeps requesting
      apply_reset("rst2");
      v = '{2'b10, 34'h0_0000_2000, 2'b01, 34'h0_0000_0100, 1'b0, -1, 1'b1, 1'b1};
      do_txn("lock wb", v);
      v = '{2'b10, 34'h0_0000_2000, 2'b10, 34'h0_0000_0100, 1'b0, -1, 1'b1, 1'b0};
      do_txn("lock refill", v);
      v = '{2'b10, 34'h0_0000_2000, 2'b00, 34'h0, 1'b0, -1, 1'b0, 1'b0};
      do_txn("lock ifill", v);

      // both caches requesting fills every round
      apply_reset("rst3");
      for (int k = 0; k < 4; k++) begin
`ifdef CACHEBUSARB_RR_EN
         v = '{2'b10, 34'h0_0000_3000, 2'b10, 34'h0_0000_4000, 1'b0, -1, (k % 2 == 0), 1'b0};
`else
         v = '{2'b10, 34'h0_0000_3000, (k < 3) ? 2'b10 : 2'b00, 34'h0_0000_4000, 1'b0, -1, (k < 3), 1'b0};
`endif
         do_txn($sformatf("arb%0d", k), v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
